// File: rtl/cmul_sequencer_if.sv
// cmul_sequencer_if
// Bundles the operand/result handshake of the complex-multiplier sequencer.
//   in_valid / in_ready   : operand handshake (Reb, Imb, Rew, Imw, n bits each)
//   out_valid / out_ready : result handshake (RE, IM, 2n+1 bits each)
//   busy                  : sequencer is not idle
// Modports: master = operand source / result sink, slave = the sequencer.
interface cmul_sequencer_if #(
    parameter int n = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [n-1:0]      Reb;
    logic [n-1:0]      Imb;
    logic [n-1:0]      Rew;
    logic [n-1:0]      Imw;
    logic              out_valid;
    logic              out_ready;
    logic [2*n:0]      RE;
    logic [2*n:0]      IM;
    logic              busy;

    modport master (
        output in_valid, Reb, Imb, Rew, Imw, out_ready,
        input  in_ready, out_valid, RE, IM, busy
    );

    modport slave (
        input  in_valid, Reb, Imb, Rew, Imw, out_ready,
        output in_ready, out_valid, RE, IM, busy
    );
endinterface

// File: rtl/cmul_sequencer.sv
// cmul_sequencer
// Sequential complex multiplier (a + jb) * (c + jd) for the FFT twiddle stage,
// using a single n x n unsigned magnitude multiplier over four cycles.
//   RE = ac - bd, IM = ad + bc, both 2n+1 bit two's complement.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears all state
//   bus  : cmul_sequencer_if.slave (operand/result handshakes, busy)
// Optional feature macro: CMUL_ROUND_EN
//   defined   -> results rescaled by (acc + 2^(n-2)) >>> (n-1) (Q(n-1) twiddle, round half up)
//   undefined -> full-precision results
module cmul_sequencer #(
    parameter int n = 8
) (
    input  logic               clk,
    input  logic               rst,
    cmul_sequencer_if.slave    bus
);
    localparam int W = 2*n + 1;
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P_AC = 3'd1,
        P_BD = 3'd2,
        P_AD = 3'd3,
        P_BC = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [n-1:0]   a_r, b_r, c_r, d_r;
    logic [W-1:0]   re_acc_r, im_acc_r;
    logic [W-1:0]   re_acc_nxt_s, im_acc_nxt_s;
    logic [W-1:0]   re_r, im_r;
    logic           out_valid_r, busy_r, in_ready_r;

    logic [n-1:0]   x_s, y_s;
    logic           sub_s;
    logic           neg_s;
    logic [2*n-1:0] prod_s;
    logic [W-1:0]   ext_s, term_s;

    // Magnitude of an n-bit two's complement value; the most negative value
    // maps to 2^(n-1), which still fits in n unsigned bits.
    function automatic logic [n-1:0] mag(input logic [n-1:0] v);
        logic [n-1:0] one_n;
        one_n = {{(n-1){1'b0}}, 1'b1};
        if (v[n-1]) begin
            mag = ~v + one_n;
        end else begin
            mag = v;
        end
    endfunction

`ifdef CMUL_ROUND_EN
    localparam logic [W-1:0] RND_W = ONE_W << (n-2);

    // Rescale a Q(n-1) product sum with round half up.
    function automatic logic [W-1:0] scale(input logic [W-1:0] acc);
        logic signed [W-1:0] t;
        t = $signed(acc + RND_W);
        scale = $unsigned(t >>> (n-1));
    endfunction
`else
    // Full-precision result, no rescale.
    function automatic logic [W-1:0] scale(input logic [W-1:0] acc);
        scale = acc;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: fixed four product cycles, then wait in DONE for out_ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (bus.in_valid) state_nxt_s = P_AC; else state_nxt_s = IDLE;
            P_AC:    state_nxt_s = P_BD;
            P_BD:    state_nxt_s = P_AD;
            P_AD:    state_nxt_s = P_BC;
            P_BC:    state_nxt_s = DONE;
            DONE:    if (bus.out_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand pair and effective operation for the current product cycle.
    always_comb begin
        x_s   = a_r;
        y_s   = c_r;
        sub_s = 1'b0;
        case (state_r)
            P_AC:    begin x_s = a_r; y_s = c_r; sub_s = 1'b0; end
            P_BD:    begin x_s = b_r; y_s = d_r; sub_s = 1'b1; end
            P_AD:    begin x_s = a_r; y_s = d_r; sub_s = 1'b0; end
            P_BC:    begin x_s = b_r; y_s = c_r; sub_s = 1'b0; end
            default: begin x_s = a_r; y_s = c_r; sub_s = 1'b0; end
        endcase
    end

    // Shared magnitude multiply; a negative operand sign flips add/subtract.
    always_comb begin
        prod_s = mag(x_s) * mag(y_s);
        neg_s  = sub_s ^ x_s[n-1] ^ y_s[n-1];
        ext_s  = {1'b0, prod_s};
        if (neg_s) begin
            term_s = ~ext_s + ONE_W;
        end else begin
            term_s = ext_s;
        end
    end

    // Accumulator update: cleared on accept, one term per product cycle.
    always_comb begin
        re_acc_nxt_s = re_acc_r;
        im_acc_nxt_s = im_acc_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    re_acc_nxt_s = {W{1'b0}};
                    im_acc_nxt_s = {W{1'b0}};
                end else begin
                    re_acc_nxt_s = re_acc_r;
                    im_acc_nxt_s = im_acc_r;
                end
            end
            P_AC, P_BD: re_acc_nxt_s = re_acc_r + term_s;
            P_AD, P_BC: im_acc_nxt_s = im_acc_r + term_s;
            default: begin
                re_acc_nxt_s = re_acc_r;
                im_acc_nxt_s = im_acc_r;
            end
        endcase
    end

    // Datapath registers: operands, accumulators and the published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {n{1'b0}};
            b_r      <= {n{1'b0}};
            c_r      <= {n{1'b0}};
            d_r      <= {n{1'b0}};
            re_acc_r <= {W{1'b0}};
            im_acc_r <= {W{1'b0}};
            re_r     <= {W{1'b0}};
            im_r     <= {W{1'b0}};
        end else begin
            re_acc_r <= re_acc_nxt_s;
            im_acc_r <= im_acc_nxt_s;
            if (state_r == IDLE && bus.in_valid) begin
                a_r <= bus.Reb;
                b_r <= bus.Imb;
                c_r <= bus.Rew;
                d_r <= bus.Imw;
            end
            // The last imaginary term lands in the same edge, so take the next value.
            if (state_r == P_BC) begin
                re_r <= scale(re_acc_nxt_s);
                im_r <= scale(im_acc_nxt_s);
            end
        end
    end

    // Status outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.RE        = re_r;
    assign bus.IM        = im_r;
endmodule

// File: tb/tb_cmul_sequencer.sv
module tb_cmul_sequencer;
    localparam int N = 8;
    localparam int W = 2*N + 1;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } res_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    res_t exp_q[$];

    cmul_sequencer_if #(.n(N)) bus ();

    cmul_sequencer #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int scale_ref(input int v);
`ifdef CMUL_ROUND_EN
        return (v + 64) >>> 7;
`else
        return v;
`endif
    endfunction

    function automatic res_t model(input int a, input int b, input int c, input int d);
        res_t r;
        r.re = W'(scale_ref(a*c - b*d));
        r.im = W'(scale_ref(a*d + b*c));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Result monitor: every consumed output is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got RE=0x%0h IM=0x%0h, expected none", bus.RE, bus.IM);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                tests++;
                if (bus.RE !== e.re || bus.IM !== e.im) begin
                    fails++;
                    $display("FAIL result: got RE=0x%0h IM=0x%0h, expected RE=0x%0h IM=0x%0h",
                             bus.RE, bus.IM, e.re, e.im);
                end
            end
        end
    end

    // Presents one operand set, waits (bounded) for in_ready, optionally records the expectation.
    task automatic send(input int a, input int b, input int c, input int d, input bit push);
        int budget;
        budget = 0;
        bus.in_valid = 1'b1;
        bus.Reb = N'(a);
        bus.Imb = N'(b);
        bus.Rew = N'(c);
        bus.Imw = N'(d);
        while (!bus.in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) check("send_timeout", 32'(budget), 32'd0);
        if (push) exp_q.push_back(model(a, b, c, d));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles (bounded) until out_valid rises.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int   cyc;
        int   budget;
        res_t h;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.Reb = '0; bus.Imb = '0; bus.Rew = '0; bus.Imw = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_RE",        32'(bus.RE),        32'd0);

        // 3+4j times 5+6j: latency 5 edges from accept, then IDLE one cycle later.
        send(3, 4, 5, 6, 1'b1);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("in_ready_busy",     32'(bus.in_ready), 32'd0);
        wait_valid(cyc);
        check("latency", 32'(cyc), 32'd4);
        @(posedge clk); #1;
        check("idle_after_done_busy",  32'(bus.busy),      32'd0);
        check("idle_after_done_valid", 32'(bus.out_valid), 32'd0);
        check("idle_after_done_ready", 32'(bus.in_ready),  32'd1);
        h = model(3, 4, 5, 6);
        check("RE_held_in_idle", 32'(bus.RE), 32'(h.re));

        // Reset mid P_AD discards the operation.
        send(7, -2, 9, 11, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_RE",        32'(bus.RE),        32'd0);
        check("midreset_IM",        32'(bus.IM),        32'd0);
        check("midreset_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_idle",     32'(bus.busy),     32'd0);

        // Most negative operands: magnitude and accumulator headroom.
        send(-128, 0, -128, 0, 1'b1);
        send(-128, -128, -128, -128, 1'b1);
`ifdef CMUL_ROUND_EN
        h = model(-128, -128, -128, -128);
        check("headroom_round_model", 32'(h.im), 32'd256);
`else
        h = model(-128, -128, -128, -128);
        check("headroom_model", 32'(h.im), 32'd32768);
`endif

        // Back-pressure: result holds while out_ready low, new operands wait.
        wait_valid(cyc);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(3, 4, 5, 6, 1'b1);
        wait_valid(cyc);
        h = model(3, 4, 5, 6);
        bus.in_valid = 1'b1;
        bus.Reb = 8'd1; bus.Imb = 8'd2; bus.Rew = 8'd3; bus.Imw = 8'd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_RE",        32'(bus.RE),        32'(h.re));
            check("hold_IM",        32'(bus.IM),        32'(h.im));
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        send(1, 2, 3, 4, 1'b1);
        wait_valid(cyc);
        check("second_after_release", 32'(cyc), 32'd4);

        // Random back-to-back operand sets.
        for (int i = 0; i < 1000; i++) begin
            int ra, rb, rc, rd;
            ra = int'($signed(8'($urandom_range(0, 255))));
            rb = int'($signed(8'($urandom_range(0, 255))));
            rc = int'($signed(8'($urandom_range(0, 255))));
            rd = int'($signed(8'($urandom_range(0, 255))));
            send(ra, rb, rc, rd, 1'b1);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
